pixel_collect3: RTL and testbench

//  Return path of the multi-engine pixel pipeline. Gathers one result per engine per group,

---
 rtl/pixel_collect3.sv | 118 +++++++++++
 tb/tb_pixel_collect3.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_collect3.sv
// Gathers one result per engine per group, then streams the group out in raster order with sof/eol.
// Define PIXEL_COLLECT_FRAME_CNT_EN to add the frame_cnt output (completed frames, wraps at 2^16).
module pixel_collect3 #(
    parameter int PIXEL_DATA_WIDTH = 32,
    parameter int SCREEN_WIDTH     = 640,
    parameter int SCREEN_HEIGHT    = 480,
    parameter int NUM_ENGINES      = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_ENGINES-1:0]                  eng_valid,
    input  logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_data,
    output logic                                    fin_flag,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [PIXEL_DATA_WIDTH-1:0]             out_data,
    output logic                                    out_sof,
    output logic                                    out_eol
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
    ,
    output logic [15:0]                             frame_cnt
`endif
);

    localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int IW = (NUM_ENGINES   > 1) ? $clog2(NUM_ENGINES)   : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(SCREEN_HEIGHT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ENGINES - 1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                      state, state_next;
    logic [NUM_ENGINES-1:0]      got, got_next, capture;
    logic [PIXEL_DATA_WIDTH-1:0] pix_buf [NUM_ENGINES];
    logic [IW-1:0]               idx;
    logic [XW-1:0]               x;
    logic [YW-1:0]               y;
    logic                        fin_next, transfer;

    // First capture per engine wins; the group is complete once every engine has been captured.
    always_comb begin
        state_next = state;
        got_next   = got;
        capture    = '0;
        fin_next   = 1'b0;
        transfer   = (state == DRAIN) && out_ready;
        out_valid  = (state == DRAIN);
        out_data   = '0;
        out_sof    = 1'b0;
        out_eol    = 1'b0;
        case (state)
            COLLECT: begin
                capture  = eng_valid & ~got;
                got_next = got | capture;
                if (&got_next) begin
                    state_next = DRAIN;
                    fin_next   = 1'b1;
                end
            end
            DRAIN: begin
                out_data = pix_buf[idx];
                out_sof  = (x == '0) && (y == '0);
                out_eol  = (x == X_LAST);
                if (transfer && (idx == IDX_LAST)) begin
                    state_next = COLLECT;
                    got_next   = '0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Raster position advances per accepted pixel, independent of group boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= COLLECT;
            got      <= '0;
            idx      <= '0;
            x        <= '0;
            y        <= '0;
            fin_flag <= 1'b0;
        end else begin
            state    <= state_next;
            got      <= got_next;
            fin_flag <= fin_next;
            if (transfer) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (capture[i]) begin
                pix_buf[i] <= eng_data[i*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH];
            end
        end
    end

`ifdef PIXEL_COLLECT_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (transfer && (x == X_LAST) && (y == Y_LAST)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_collect3.sv
// Bench for pixel_collect3: a full-size instance and a tiny-screen instance share all inputs,
// checked every cycle against a queue/pixel-count model plus hand-computed literal pins.
`timescale 1ns/1ps
module tb_pixel_collect3;

    localparam int PDW   = 32;
    localparam int NE    = 3;
    localparam int BIG_W = 640;
    localparam int BIG_H = 480;
    localparam int SML_W = 8;
    localparam int SML_H = 4;
    localparam logic [PDW-1:0] SEQ = 32'h1000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NE-1:0]     eng_valid;
    logic [NE*PDW-1:0] eng_data;
    logic              out_ready;

    logic           fin_a, valid_a, sof_a, eol_a;
    logic [PDW-1:0] data_a;
    logic           fin_b, valid_b, sof_b, eol_b;
    logic [PDW-1:0] data_b;
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
    logic [15:0]    frame_a, frame_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [PDW-1:0] exp_q[$];
    int pix_cnt = 0;
    int grp_pos = 0;
    int fins_a = 0;
    int fins_b = 0;
    int groups_sent = 0;
    int phase = 0;
    bit chk_en = 1'b0;
    bit group_done = 1'b0;

    always #5 clk = ~clk;

    pixel_collect3 u_dut (
        .clk(clk), .reset(reset), .eng_valid(eng_valid), .eng_data(eng_data),
        .fin_flag(fin_a), .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
        .out_sof(sof_a), .out_eol(eol_a)
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
        , .frame_cnt(frame_a)
`endif
    );

    pixel_collect3 #(.SCREEN_WIDTH(SML_W), .SCREEN_HEIGHT(SML_H)) u_small (
        .clk(clk), .reset(reset), .eng_valid(eng_valid), .eng_data(eng_data),
        .fin_flag(fin_b), .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
        .out_sof(sof_b), .out_eol(eol_b)
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
        , .frame_cnt(frame_b)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NE-1:0] v, input logic [PDW-1:0] d0,
                                 input logic [PDW-1:0] d1, input logic [PDW-1:0] d2);
        eng_valid = v;
        eng_data  = {d2, d1, d0};
    endtask

    task automatic expectGroup(input logic [PDW-1:0] d0, input logic [PDW-1:0] d1, input logic [PDW-1:0] d2);
        exp_q.push_back(d0);
        exp_q.push_back(d1);
        exp_q.push_back(d2);
        groups_sent++;
    endtask

    task automatic waitFin(input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (fin_a) found = 1'b1;
        end
        if (!found) checkOutput("fin_timeout", fin_a, 1'b1);
    endtask

    // Model: expected pixels in a queue; sof/eol/frame follow from the count of accepted pixels.
    always @(negedge clk) begin
        if (chk_en) begin
            if (group_done) begin
                checkOutput("gap_valid", {valid_b, valid_a}, 2'b00);
                group_done = 1'b0;
            end
            if (fin_a) begin
                fins_a++;
                checkOutput("fin_with_valid", valid_a, 1'b1);
                checkOutput("fin_group_start", grp_pos, 0);
            end
            if (fin_b) fins_b++;
            if (valid_a || valid_b) begin
                if (exp_q.size() == 0) begin
                    checkOutput("valid_unexpected", {valid_b, valid_a}, 2'b00);
                end else begin
                    checkOutput("valid_a", valid_a, 1'b1);
                    checkOutput("valid_b", valid_b, 1'b1);
                    checkOutput("data_a", data_a, exp_q[0]);
                    checkOutput("data_b", data_b, exp_q[0]);
                    checkOutput("sof_a", sof_a, (pix_cnt % (BIG_W*BIG_H)) == 0);
                    checkOutput("eol_a", eol_a, (pix_cnt % BIG_W) == BIG_W-1);
                    checkOutput("sof_b", sof_b, (pix_cnt % (SML_W*SML_H)) == 0);
                    checkOutput("eol_b", eol_b, (pix_cnt % SML_W) == SML_W-1);
                    if (phase == 4) begin
                        if (exp_q[0] == SEQ + 639)  checkOutput("pin_eol_639", eol_a, 1'b1);
                        if (exp_q[0] == SEQ + 640)  checkOutput("pin_line1_start", {sof_a, eol_a}, 2'b00);
                        if (exp_q[0] == SEQ + 1279) checkOutput("pin_eol_1279", eol_a, 1'b1);
                        if (exp_q[0] == SEQ + 7)    checkOutput("pin_small_eol_7", {sof_b, eol_b}, 2'b01);
                        if (exp_q[0] == SEQ + 31)   checkOutput("pin_small_last", eol_b, 1'b1);
                        if (exp_q[0] == SEQ + 32)   checkOutput("pin_small_sof", sof_b, 1'b1);
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
                        if (exp_q[0] == SEQ + 32)   checkOutput("pin_small_frame", frame_b, 16'd1);
`endif
                    end
                end
            end
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
            checkOutput("frame_a", frame_a, 64'((pix_cnt / (BIG_W*BIG_H)) % 65536));
            checkOutput("frame_b", frame_b, 64'((pix_cnt / (SML_W*SML_H)) % 65536));
`endif
            if (reset) begin
                exp_q.delete();
                pix_cnt    = 0;
                grp_pos    = 0;
                group_done = 1'b0;
            end else if (valid_a && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pix_cnt++;
                grp_pos++;
                if (grp_pos == NE) begin
                    grp_pos    = 0;
                    group_done = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        applyStimulus('0, '0, '0, '0);
        repeat (3) tick();
        chk_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_fin", {fin_b, fin_a}, 2'b00);
        checkOutput("rst_valid", {valid_b, valid_a}, 2'b00);
        checkOutput("rst_data", data_a, 32'h0);
        checkOutput("rst_sof_eol", {sof_b, eol_b, sof_a, eol_a}, 4'b0000);
`ifdef PIXEL_COLLECT_FRAME_CNT_EN
        checkOutput("rst_frame", {frame_b, frame_a}, 32'h0);
`endif

        // All engines ready at once: fin and first pixel one cycle after capture.
        tick(); reset = 1'b0;
        expectGroup(32'd10, 32'd20, 32'd30);
        applyStimulus(3'b111, 32'd10, 32'd20, 32'd30);
        @(negedge clk); checkOutput("t1_c1_fin_valid", {fin_a, valid_a}, 2'b00);
        tick(); @(negedge clk);
        checkOutput("t1_c2_fin_valid", {fin_a, valid_a}, 2'b11);
        checkOutput("t1_c2_data", data_a, 32'd10);
        checkOutput("t1_c2_sof", sof_a, 1'b1);
        tick(); applyStimulus('0, '0, '0, '0); @(negedge clk);
        checkOutput("t1_c3_fin", fin_a, 1'b0);
        checkOutput("t1_c3_data", data_a, 32'd20);
        checkOutput("t1_c3_sof", sof_a, 1'b0);
        tick(); @(negedge clk); checkOutput("t1_c4_data", data_a, 32'd30);
        tick(); @(negedge clk); checkOutput("t1_c5_valid", valid_a, 1'b0);

        // Staggered completion; slice 0 changes after its capture and must be ignored.
        tick(); expectGroup(32'hA0, 32'hA1, 32'hA2);
        applyStimulus(3'b001, 32'hA0, 32'h0, 32'h0);
        @(negedge clk); checkOutput("t2_c1_fin", fin_a, 1'b0);
        tick(); @(negedge clk); checkOutput("t2_c2_fin", fin_a, 1'b0);
        tick(); applyStimulus(3'b101, 32'hBAD0, 32'h0, 32'hA2);
        @(negedge clk); checkOutput("t2_c3_fin", fin_a, 1'b0);
        tick(); @(negedge clk); checkOutput("t2_c4_fin", fin_a, 1'b0);
        tick(); applyStimulus(3'b111, 32'hBAD1, 32'hA1, 32'hA2);
        @(negedge clk); checkOutput("t2_c5_fin", fin_a, 1'b0);
        tick(); @(negedge clk);
        checkOutput("t2_c6_fin", fin_a, 1'b1);
        checkOutput("t2_c6_data", data_a, 32'hA0);
        tick(); applyStimulus('0, '0, '0, '0);
        repeat (3) tick();

        // Sink stall mid-group while the next group's data is already on the engine slices.
        tick(); expectGroup(32'hB0, 32'hB1, 32'hB2);
        applyStimulus(3'b111, 32'hB0, 32'hB1, 32'hB2);
        waitFin(10);
        tick(); out_ready = 1'b0;
        expectGroup(32'hC0, 32'hC1, 32'hC2);
        applyStimulus(3'b111, 32'hC0, 32'hC1, 32'hC2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t3_stall_valid", valid_a, 1'b1);
            checkOutput("t3_stall_data", data_a, 32'hB1);
            checkOutput("t3_stall_fin", fin_a, 1'b0);
            if (i < 3) tick();
        end
        tick(); out_ready = 1'b1;
        @(negedge clk); checkOutput("t3_resume_data", data_a, 32'hB1);
        waitFin(12);
        tick(); applyStimulus('0, '0, '0, '0);
        repeat (4) tick();

        // Long run from a clean raster position: line ends and small-screen frame wraps.
        reset = 1'b1; tick(); reset = 1'b0;
        phase = 4;
        for (int g = 0; g < 427; g++) begin
            tick();
            expectGroup(SEQ + 32'(3*g), SEQ + 32'(3*g+1), SEQ + 32'(3*g+2));
            applyStimulus(3'b111, SEQ + 32'(3*g), SEQ + 32'(3*g+1), SEQ + 32'(3*g+2));
            waitFin(12);
        end
        tick(); applyStimulus('0, '0, '0, '0);
        repeat (4) tick();

        // Reset with one pixel still buffered; the next group restarts at the frame origin.
        phase = 6;
        tick(); expectGroup(32'hD0, 32'hD1, 32'hD2);
        applyStimulus(3'b111, 32'hD0, 32'hD1, 32'hD2);
        waitFin(12);
        tick(); applyStimulus('0, '0, '0, '0);
        @(negedge clk); checkOutput("t6_data_d1", data_a, 32'hD1);
        tick(); reset = 1'b1;
        @(negedge clk); checkOutput("t6_last_pending", data_a, 32'hD2);
        tick(); reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_valid", {valid_b, valid_a}, 2'b00);
        checkOutput("t6_rst_fin", {fin_b, fin_a}, 2'b00);
        tick(); expectGroup(32'hE0, 32'hE1, 32'hE2);
        applyStimulus(3'b111, 32'hE0, 32'hE1, 32'hE2);
        waitFin(12);
        checkOutput("t6_restart_sof", {sof_b, sof_a}, 2'b11);
        checkOutput("t6_restart_data", data_a, 32'hE0);
        tick(); applyStimulus('0, '0, '0, '0);
        repeat (5) tick();

        checkOutput("fin_count_a", fins_a, groups_sent);
        checkOutput("fin_count_b", fins_b, groups_sent);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
